// File: rtl/vec_lane_mac_engine.sv
// LANES-wide mul/mac/add engine: issues len beats of reads, writes per-beat (mul/add) or one accumulated (mac) result.
// Latency: done len+RD_LAT+2 cycles after start; no backpressure, the memories take one beat per cycle.
module vec_lane_mac_engine #(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int RD_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [LEN_W-1:0]          len,
  input  logic [ADDR_W-1:0]         base_pix,
  input  logic [ADDR_W-1:0]         base_const,
  input  logic [ADDR_W-1:0]         base_out,
  output logic                      rd_en,
  output logic [LANES*ADDR_W-1:0]   rd_addr,
  input  logic [LANES*DATA_W-1:0]   pix_data,
  input  logic [LANES*DATA_W-1:0]   const_data,
  output logic                      wr_en,
  output logic [LANES*ADDR_W-1:0]   wr_addr,
  output logic [LANES*DATA_W-1:0]   wr_data,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, WRITE, FINISH} state_t;

  state_t              state;
  logic [1:0]          mode_q;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    issue_cnt;
  logic [LEN_W-1:0]    ret_cnt;
  logic [ADDR_W-1:0]   base_pix_q;
  logic [ADDR_W-1:0]   base_out_q;
  logic [RD_LAT-1:0]   vpipe;
  logic [DATA_W-1:0]   acc     [LANES];
  logic [DATA_W-1:0]   pix_w   [LANES];
  logic [DATA_W-1:0]   cst_w   [LANES];
  logic [DATA_W-1:0]   prod    [LANES];
  logic [DATA_W-1:0]   res     [LANES];
  logic [DATA_W-1:0]   acc_nxt [LANES];
  logic                ret_vld;
  logic                ret_last;

  // The constant memory shares rd_addr, so its base never enters the datapath.
  logic unused_base_const;
  assign unused_base_const = ^base_const;

  assign ret_vld  = vpipe[RD_LAT-1];
  assign ret_last = ret_vld && (ret_cnt == len_q - LEN_W'(1));

  function automatic logic [ADDR_W-1:0] lane_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  beat,
                                                  input int                lane);
    lane_addr = base + ((ADDR_W'(beat) * ADDR_W'(LANES) + ADDR_W'(lane)) << 2);
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      pix_w[i]   = pix_data[i*DATA_W +: DATA_W];
      cst_w[i]   = const_data[i*DATA_W +: DATA_W];
      prod[i]    = pix_w[i] * cst_w[i];
      acc_nxt[i] = acc[i] + prod[i];
      res[i]     = (mode_q == 2'd2) ? (pix_w[i] + cst_w[i]) : prod[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      mode_q     <= '0;
      len_q      <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      base_pix_q <= '0;
      base_out_q <= '0;
      vpipe      <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      for (int i = 0; i < LANES; i++) acc[i] <= '0;
    end else begin
      vpipe <= (vpipe << 1) | RD_LAT'(rd_en);
      done  <= 1'b0;
      err   <= 1'b0;
      wr_en <= 1'b0;

      if (ret_vld) begin
        ret_cnt <= ret_cnt + LEN_W'(1);
        if (mode_q == 2'd1) begin
          for (int i = 0; i < LANES; i++) acc[i] <= acc_nxt[i];
        end else begin
          wr_en <= 1'b1;
          for (int i = 0; i < LANES; i++) begin
            wr_addr[i*ADDR_W +: ADDR_W] <= lane_addr(base_out_q, ret_cnt, i);
            wr_data[i*DATA_W +: DATA_W] <= res[i];
          end
        end
      end

      case (state)
        ISSUE: begin
          if (issue_cnt == len_q) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            issue_cnt <= issue_cnt + LEN_W'(1);
            for (int i = 0; i < LANES; i++)
              rd_addr[i*ADDR_W +: ADDR_W] <= lane_addr(base_pix_q, issue_cnt, i);
          end
        end
        DRAIN: begin
          if (ret_last) begin
            state <= WRITE;
            // mac folds the final return straight into its single write-back
            if (mode_q == 2'd1) begin
              wr_en <= 1'b1;
              for (int i = 0; i < LANES; i++) begin
                wr_addr[i*ADDR_W +: ADDR_W] <= lane_addr(base_out_q, '0, i);
                wr_data[i*DATA_W +: DATA_W] <= acc_nxt[i];
              end
            end
          end
        end
        WRITE: begin
          state <= FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          // IDLE and the done cycle (FINISH) both accept a new request
          state <= IDLE;
          if (start) begin
            if (mode == 2'd3) begin
              err <= 1'b1;
            end else if (len == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state      <= ISSUE;
              mode_q     <= mode;
              len_q      <= len;
              base_pix_q <= base_pix;
              base_out_q <= base_out;
              issue_cnt  <= LEN_W'(1);
              ret_cnt    <= '0;
              busy       <= 1'b1;
              rd_en      <= 1'b1;
              for (int i = 0; i < LANES; i++) begin
                acc[i]                      <= '0;
                rd_addr[i*ADDR_W +: ADDR_W] <= lane_addr(base_pix, '0, i);
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_lane_mac_engine.sv
// Bench for vec_lane_mac_engine: directed scenarios plus randomized requests against a cycle-level reference.
// Memory model returns data RD_LAT cycles after each read strobe.
module tb_vec_lane_mac_engine;
  localparam int LANES  = 4;
  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int LW     = 16;
  localparam int RD_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  start;
  logic [1:0]            mode;
  logic [LW-1:0]         len;
  logic [AW-1:0]         base_pix, base_const, base_out;
  logic                  rd_en;
  logic [LANES*AW-1:0]   rd_addr;
  logic [LANES*DW-1:0]   pix_data, const_data;
  logic                  wr_en;
  logic [LANES*AW-1:0]   wr_addr;
  logic [LANES*DW-1:0]   wr_data;
  logic                  busy, done, err;

  vec_lane_mac_engine #(.LANES(LANES), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .len(len),
    .base_pix(base_pix), .base_const(base_const), .base_out(base_out),
    .rd_en(rd_en), .rd_addr(rd_addr), .pix_data(pix_data), .const_data(const_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cur_c = 0;
  int          pat   = 0;
  logic [31:0] pbase, pval, cval, salt;
  logic [31:0] exp_rd_addr [LANES];
  logic [31:0] exp_wr_addr [LANES];
  logic [31:0] exp_wr_data [LANES];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cur_c, got, exp);
    end
  endtask

  // Memory contents as a function of byte address.
  function automatic logic [31:0] pix_of(input logic [31:0] a);
    case (pat)
      1:       return ((a - pbase) >> 2) + 32'd1;
      2:       return (((a - pbase) >> 2) / LANES) + 32'd1;
      3:       return pval;
      default: return (a * 32'h9E37_79B1) ^ salt;
    endcase
  endfunction

  function automatic logic [31:0] cst_of(input logic [31:0] a);
    if (pat != 0) return cval;
    return (a ^ salt) * 32'h85EB_CA6B + 32'd7;
  endfunction

  function automatic logic [31:0] lane_op(input logic [1:0] m, input logic [31:0] p, input logic [31:0] c);
    logic [63:0] f;
    f = (m == 2'd2) ? (64'(p) + 64'(c)) : (64'(p) * 64'(c));
    return f[31:0];
  endfunction

  typedef struct { logic en; logic [LANES*AW-1:0] a; } rd_req_t;
  rd_req_t rq[$];

  initial begin
    rd_req_t r;
    pix_data   = '0;
    const_data = '0;
    forever begin
      @(negedge clk);
      r.en = rd_en;
      r.a  = rd_addr;
      rq.push_back(r);
      if (rq.size() > RD_LAT) begin
        r = rq.pop_front();
        for (int i = 0; i < LANES; i++) begin
          pix_data[i*DW +: DW]   = r.en ? pix_of(r.a[i*AW +: AW]) : $urandom;
          const_data[i*DW +: DW] = r.en ? cst_of(r.a[i*AW +: AW]) : $urandom;
        end
      end
    end
  end

  task automatic check_outputs(input logic e_rd, input logic e_wr, input logic e_busy,
                               input logic e_done, input logic e_err);
    chk("rd_en", 32'(rd_en), 32'(e_rd));
    chk("wr_en", 32'(wr_en), 32'(e_wr));
    chk("busy",  32'(busy),  32'(e_busy));
    chk("done",  32'(done),  32'(e_done));
    chk("err",   32'(err),   32'(e_err));
    for (int i = 0; i < LANES; i++) begin
      chk($sformatf("rd_addr[%0d]", i), rd_addr[i*AW +: AW], exp_rd_addr[i]);
      chk($sformatf("wr_addr[%0d]", i), wr_addr[i*AW +: AW], exp_wr_addr[i]);
      chk($sformatf("wr_data[%0d]", i), wr_data[i*DW +: DW], exp_wr_data[i]);
    end
  endtask

  task automatic idle(input int k);
    for (int c = 0; c < k; c++) begin
      @(negedge clk);
      cur_c = -1;
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Entered at a negedge: that cycle is cycle 0. Returns at the negedge of the last checked cycle.
  task automatic run_op(input logic [1:0] m, input int n, input logic [31:0] bp,
                        input logic [31:0] bc, input logic [31:0] bo,
                        input int busy_start, input int rst_at);
    int          last, b;
    logic        ab, e_rd, e_wr, e_busy, e_done, e_err;
    logic [31:0] a;
    logic [31:0] macc [LANES];
    last  = (m == 2'd3 || n == 0) ? 1 : n + RD_LAT + 2;
    if (rst_at > 0) last = rst_at + 3;
    pbase = bp;
    for (int i = 0; i < LANES; i++) begin
      macc[i] = 32'd0;
      for (int bb = 0; bb < n; bb++) begin
        a       = bp + 32'((bb*LANES + i) * 4);
        macc[i] = macc[i] + lane_op(2'd0, pix_of(a), cst_of(a));
      end
    end
    mode = m; len = LW'(n); base_pix = bp; base_const = bc; base_out = bo; start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      cur_c  = c;
      ab     = (rst_at > 0) && (c > rst_at);
      e_rd   = !ab && m != 2'd3 && n > 0 && c <= n;
      e_wr   = !ab && n > 0 && ((m != 2'd1 && m != 2'd3 && c >= 2 + RD_LAT && c <= 1 + n + RD_LAT) ||
                                (m == 2'd1 && c == n + RD_LAT + 1));
      e_busy = !ab && m != 2'd3 && n > 0 && c <= n + RD_LAT + 1;
      e_done = !ab && m != 2'd3 && ((n == 0 && c == 1) || (n > 0 && c == n + RD_LAT + 2));
      e_err  = !ab && m == 2'd3 && c == 1;
      for (int i = 0; i < LANES; i++) begin
        if (ab && c == rst_at + 1) begin
          exp_rd_addr[i] = '0; exp_wr_addr[i] = '0; exp_wr_data[i] = '0;
        end
        if (e_rd) exp_rd_addr[i] = bp + 32'(((c-1)*LANES + i) * 4);
        if (e_wr) begin
          if (m == 2'd1) begin
            exp_wr_addr[i] = bo + 32'(i * 4);
            exp_wr_data[i] = macc[i];
          end else begin
            b              = c - 2 - RD_LAT;
            a              = bp + 32'((b*LANES + i) * 4);
            exp_wr_addr[i] = bo + 32'((b*LANES + i) * 4);
            exp_wr_data[i] = lane_op(m, pix_of(a), cst_of(a));
          end
        end
      end
      check_outputs(e_rd, e_wr, e_busy, e_done, e_err);
      if (c == 1) begin
        start = 1'b0;
        mode = 2'($urandom); len = LW'($urandom); base_pix = $urandom; base_out = $urandom;
      end
      if (c == busy_start) start = 1'b1;
      else if (busy_start > 0 && c == busy_start + 1) start = 1'b0;
      if (c == rst_at) rst = 1'b0;
      else if (rst_at > 0 && c == rst_at + 1) rst = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  m;
    logic [31:0] bp, bo;
    rst = 1'b0; start = 1'b0; mode = '0; len = '0;
    base_pix = '0; base_const = '0; base_out = '0;
    salt = $urandom; pval = '0; cval = '0; pbase = '0;
    for (int i = 0; i < LANES; i++) begin
      exp_rd_addr[i] = '0; exp_wr_addr[i] = '0; exp_wr_data[i] = '0;
    end
    repeat (3) @(negedge clk);
    cur_c = 0;
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    idle(2);

    pat = 1; cval = 32'd2;
    run_op(2'd0, 2, 32'h100, 32'h200, 32'h300, 0, 0);
    idle(1);
    pat = 2; cval = 32'd3;
    run_op(2'd1, 3, 32'h100, 32'h200, 32'h300, 0, 0);
    idle(1);
    pat = 3; pval = 32'hFFFF_FFFF; cval = 32'd2;
    run_op(2'd2, 1, 32'h100, 32'h200, 32'h300, 0, 0);
    pval = 32'h8000_0000;
    run_op(2'd0, 1, 32'h100, 32'h200, 32'h400, 0, 0);
    idle(1);
    run_op(2'd0, 0, 32'h100, 32'h200, 32'h300, 0, 0);
    idle(1);
    run_op(2'd3, 4, 32'h100, 32'h200, 32'h300, 0, 0);
    idle(1);
    pat = 0;
    run_op(2'd0, 4, 32'h1000, 32'h2000, 32'h3000, 2, 0);
    idle(1);
    run_op(2'd0, 4, 32'h1000, 32'h2000, 32'h3000, 0, 2);
    run_op(2'd2, 1, 32'h500, 32'h600, 32'h700, 0, 0);
    idle(1);
    run_op(2'd1, 5, 32'hFFFF_FFE0, 32'h0, 32'hFFFF_FFF8, 0, 0);

    for (int k = 0; k < 40; k++) begin
      salt = $urandom;
      m    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bp   = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      bo   = $urandom & 32'hFFFF_FFFC;
      run_op(m, $urandom_range(0, 6), bp, $urandom, bo, $urandom_range(0, 1) * 3, 0);
      idle($urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
